instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch unit. Reads program memory at the address held by the PC
//  counter and advances the counter through its PC_inc strobe.
//  Buffers fetched words in a small FIFO and hands them to the decoder over a
//  valid/ready handshake. Sits between the PC counter, program memory and the decoder.
// PARAMETERS
//  AW     8   address width; matches the PC width
//  DW     16  instruction word width
//  DEPTH  2   FIFO entries; must be a power of two, 2 or 4
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  pc_in         in   AW  current PC from the counter
//  pc_inc        out  1   advance strobe to the counter (drives PC_inc)
//  flush         in   1   PC was loaded (branch); discard buffered and in-flight words
//  mem_req       out  1   program memory read request
//  mem_addr      out  AW  read address; stable while mem_req=1
//  mem_ack       in   1   read done; mem_rdata valid in the same cycle
//  mem_rdata     in   DW  read data
//  instr_valid   out  1   FIFO head valid
//  instr_data    out  DW  FIFO head instruction
//  instr_pc      out  AW  FIFO head address
//  instr_ready   in   1   decoder accepts the head this cycle
//  mem_rparity   in   1   even parity of mem_rdata   [PARITY_CHECK_EN only]
//  parity_err    out  1   sticky parity error flag   [PARITY_CHECK_EN only]
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately):
//   - state=IDLE; FIFO empty; discard=0
//   - mem_req, mem_addr, instr_valid, pc_inc and parity_err all 0
//  FSM states: IDLE, REQ, ADV.
//   - IDLE: if (count<DEPTH && !flush): go to REQ, register mem_addr<=pc_in, mem_req<=1.
//   - REQ: mem_req stays 1 and mem_addr stays stable until mem_ack; a request is never retracted.
//       On mem_ack with discard=0: push {mem_addr, mem_rdata}; go to ADV.
//       On mem_ack with discard=1: drop the data; clear discard; go to IDLE.
//       mem_req is 0 in the cycle after ack.
//   - ADV: pc_inc = (state==ADV) & ~flush (combinational, exactly one cycle). Next: IDLE.
//       IDLE samples pc_in one cycle after ADV, after the counter has updated.
//  Throughput: at most one word per 3 cycles with a zero-wait memory (ack in the first REQ cycle).
//  Latency: push at the ack edge, so instr_valid=1 in the cycle after the ack.
//  FIFO: pop on instr_valid & instr_ready. Push and pop in the same cycle are legal;
//   count is unchanged. Pointers wrap modulo DEPTH. A push is never attempted
//   while full, because a request is issued only when count<DEPTH.
//  Flush (any state, sampled at the clock edge):
//   - FIFO cleared; instr_valid=0 next cycle.
//   - A pop in the same cycle is ignored; flush has priority.
//   - In REQ without ack: discard<=1.
//   - In REQ with ack in the same cycle: data dropped, no ADV.
//   - In ADV: pc_inc is suppressed; go to IDLE.
//   - In IDLE: no request this cycle.
//  Reset mid-REQ: mem_req drops asynchronously; memory must tolerate an abandoned read.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//   - Ports mem_rparity and parity_err exist.
//   - On a non-discarded ack where ^mem_rdata != mem_rparity: parity_err<=1 in the cycle after the ack.
//   - The word is still pushed.
//   - parity_err is sticky; cleared only by rst or flush.
//  PARITY_CHECK_EN undefined: both ports absent; no check logic.
// TESTING
//  1. Reset; counter model at 0x00; mem acks immediately with rdata=0x0100+addr; instr_ready=1
//     -> words (pc,data) = (00,0100),(01,0101),(02,0102), one per 3 cycles; one pc_inc per word.
//  2. instr_ready=0 for 10 cycles
//     -> exactly 2 fetches (pc 00,01), then mem_req stays 0.
//     Raise ready -> head 00 pops, fetch at 02 begins.
//  3. mem_ack delayed 3 cycles at addr 0x04
//     -> mem_req=1 and mem_addr=0x04 held for 4 cycles; one push; one pc_inc.
//  4. flush in REQ at addr 0x05, counter loaded to 0x40, ack 2 cycles later
//     -> data discarded, no pc_inc, FIFO empty, next mem_addr=0x40.
//  5. rst asserted mid-REQ with FIFO holding 1 word
//     -> mem_req, instr_valid, pc_inc =0 immediately; after release, fetch restarts at pc_in.
//  6. (PARITY_CHECK_EN) wrong mem_rparity at addr 0x03
//     -> parity_err=1 in the cycle after the ack, word still delivered; stays 1 until flush.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: reads program memory at pc_in, strobes the PC counter, queues words for decode.
// Optional `PARITY_CHECK_EN adds mem_rparity input and sticky parity_err output.
module instr_fetch #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    output logic          pc_inc,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
`ifdef PARITY_CHECK_EN
    input  logic          mem_rparity,
    output logic          parity_err,
`endif
    output logic          instr_valid,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, ADV} state_t;

    state_t        state, state_nxt;
    logic          discard;
    logic          push, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A flush coinciding with the ack drops the word and skips ADV.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: if (count < FULL && !flush) state_nxt = REQ;
            REQ: begin
                if (mem_ack) begin
                    if (!discard && !flush) begin
                        push      = 1'b1;
                        state_nxt = ADV;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            ADV:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req     = (state == REQ);
    assign pc_inc      = (state == ADV) && !flush;
    assign instr_valid = (count != '0);
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign pop         = instr_valid && instr_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            discard  <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == REQ) mem_addr <= pc_in;
            // The request cannot be retracted, so a flush marks its data for discard.
            if (state == REQ) begin
                if (mem_ack)    discard <= 1'b0;
                else if (flush) discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= mem_addr;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      parity_err <= 1'b0;
        else if (flush)                               parity_err <= 1'b0;
        else if (push && ((^mem_rdata) != mem_rparity)) parity_err <= 1'b1;
    end
`endif

endmodule
